// File: rtl/anita_trig_pkg.sv
// Shared limits, default widths and helpers for the multi-channel L1 trigger synchroniser.
package anita_trig_pkg;

    localparam int SYNC_MIN      = 2;
    localparam int SYNC_MAX      = 4;
    localparam int DEF_NCH       = 8;
    localparam int DEF_SYNC      = 3;
    localparam int DEF_HOLDOFF_W = 4;
    localparam int DEF_SCALER_W  = 16;

    // Low bit of channel ch's slice in the flattened scaler bus.
    function automatic int scaler_lo(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/anita_trig_chan.sv
// One trigger channel: edge-capture latch, synchroniser, edge detect, holdoff and gated rate scaler.
module anita_trig_chan
    import anita_trig_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC,
    parameter bit FALLING_EDGE = 1'b1,
    parameter int HOLDOFF_W    = DEF_HOLDOFF_W,
    parameter int SCALER_W     = DEF_SCALER_W
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 trig,
    input  logic                 mask,
    input  logic [HOLDOFF_W-1:0] holdoff,
    input  logic                 gate,
    output logic                 pulse,
    output logic                 level,
    output logic [SCALER_W-1:0]  snap_cnt,
    output logic                 snap_ovf
);

    (* IOB = "TRUE" *) logic cap;
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] s;

    logic                 rearm;
    logic                 det;
    logic                 issue;
    logic [HOLDOFF_W-1:0] hold_cnt;
    logic [SCALER_W-1:0]  cnt;
    logic                 ovf;

    // Rearm comes straight off the last sync flop so the async clear is glitch-free.
    assign rearm = s[SYNC_STAGES-1];
    assign level = s[SYNC_STAGES-1];

    generate
        if (FALLING_EDGE) begin : g_fall
            always_ff @(negedge trig or posedge CLR or posedge rearm) begin
                if (CLR || rearm) cap <= 1'b0;
                else              cap <= 1'b1;
            end
        end else begin : g_rise
            always_ff @(posedge trig or posedge CLR or posedge rearm) begin
                if (CLR || rearm) cap <= 1'b0;
                else              cap <= 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) s <= '0;
        else     s <= {s[SYNC_STAGES-2:0], cap};
    end

    assign det   = s[SYNC_STAGES-2] & ~s[SYNC_STAGES-1];
    assign issue = det & ~mask & (hold_cnt == '0);

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            pulse    <= 1'b0;
            hold_cnt <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            snap_cnt <= '0;
            snap_ovf <= 1'b0;
        end else begin
            pulse <= issue;
            if (issue)                hold_cnt <= holdoff;
            else if (hold_cnt != '0)  hold_cnt <= hold_cnt - HOLDOFF_W'(1);
            // Snapshot excludes this cycle's hit; it seeds the new period instead.
            if (gate) begin
                snap_cnt <= cnt;
                snap_ovf <= ovf;
                cnt      <= SCALER_W'(issue);
                ovf      <= 1'b0;
            end else if (issue) begin
                if (&cnt) ovf <= 1'b1;
                else      cnt <= cnt + SCALER_W'(1);
            end
        end
    end

endmodule

// File: rtl/anita_trig_multi_sync.sv
// NCH-channel L1 trigger synchroniser: per-channel pulses, levels and gated rate scalers.
module anita_trig_multi_sync
    import anita_trig_pkg::*;
#(
    parameter int NCH          = DEF_NCH,
    parameter int SYNC_STAGES  = DEF_SYNC,
    parameter bit FALLING_EDGE = 1'b1,
    parameter int HOLDOFF_W    = DEF_HOLDOFF_W,
    parameter int SCALER_W     = DEF_SCALER_W
) (
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic [NCH-1:0]          TRIG,
    input  logic [NCH-1:0]          MASK,
    input  logic [HOLDOFF_W-1:0]    HOLDOFF,
    input  logic                    GATE,
    output logic [NCH-1:0]          TRIG_PULSE,
    output logic [NCH-1:0]          TRIG_LEVEL,
    output logic [NCH*SCALER_W-1:0] SCALER_OUT,
    output logic [NCH-1:0]          OVERFLOW,
    output logic                    SCALER_VALID
);

    generate
        if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
            $error("anita_trig_multi_sync: SYNC_STAGES out of range");
        end

        for (genvar i = 0; i < NCH; i++) begin : g_ch
            anita_trig_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .FALLING_EDGE(FALLING_EDGE),
                .HOLDOFF_W   (HOLDOFF_W),
                .SCALER_W    (SCALER_W)
            ) u_chan (
                .CLK     (CLK),
                .CLR     (CLR),
                .trig    (TRIG[i]),
                .mask    (MASK[i]),
                .holdoff (HOLDOFF),
                .gate    (GATE),
                .pulse   (TRIG_PULSE[i]),
                .level   (TRIG_LEVEL[i]),
                .snap_cnt(SCALER_OUT[scaler_lo(i, SCALER_W) +: SCALER_W]),
                .snap_ovf(OVERFLOW[i])
            );
        end
    endgenerate

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) SCALER_VALID <= 1'b0;
        else     SCALER_VALID <= GATE;
    end

endmodule

// File: tb/tb_anita_trig_multi_sync.sv
// Scoreboard bench: expected pulses/snapshots queued at stimulus time, popped as the DUT emits them.
module tb_anita_trig_multi_sync;

    localparam int NCH = 8;
    localparam int SS  = 3;
    localparam int HW  = 4;
    localparam int SW  = 4;

    logic              CLK = 1'b0;
    logic              CLR = 1'b1;
    logic [NCH-1:0]    TRIG = '1;
    logic [NCH-1:0]    MASK = '0;
    logic [HW-1:0]     HOLDOFF = '0;
    logic              GATE = 1'b0;
    logic [NCH-1:0]    TRIG_PULSE;
    logic [NCH-1:0]    TRIG_LEVEL;
    logic [NCH*SW-1:0] SCALER_OUT;
    logic [NCH-1:0]    OVERFLOW;
    logic              SCALER_VALID;

    anita_trig_multi_sync #(
        .NCH(NCH), .SYNC_STAGES(SS), .FALLING_EDGE(1'b1), .HOLDOFF_W(HW), .SCALER_W(SW)
    ) dut (
        .CLK(CLK), .CLR(CLR), .TRIG(TRIG), .MASK(MASK), .HOLDOFF(HOLDOFF), .GATE(GATE),
        .TRIG_PULSE(TRIG_PULSE), .TRIG_LEVEL(TRIG_LEVEL), .SCALER_OUT(SCALER_OUT),
        .OVERFLOW(OVERFLOW), .SCALER_VALID(SCALER_VALID)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { int ch; int cyc; } pulse_t;
    typedef struct { int cyc; logic [NCH*SW-1:0] cnt; logic [NCH-1:0] ovf; } snap_t;

    pulse_t exp_p[$];
    snap_t  exp_s[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge CLK);
    endtask

    // Call at a negedge: falling edge lands before the next posedge, so the pulse follows SS edges later.
    task automatic fire(input int ch, input bit want);
        pulse_t e;
        if (want) begin
            e.ch  = ch;
            e.cyc = cyc + SS;
            exp_p.push_back(e);
        end
        TRIG[ch] = 1'b0;
        #2;
        TRIG[ch] = 1'b1;
    endtask

    task automatic gate_one(input int ch, input int c, input bit o);
        snap_t e;
        e.cyc = cyc + 1;
        e.cnt = '0;
        e.ovf = '0;
        e.cnt[ch*SW +: SW] = SW'(c);
        e.ovf[ch] = o;
        exp_s.push_back(e);
        GATE = 1'b1;
        @(negedge CLK);
        GATE = 1'b0;
    endtask

    task automatic drain(input string tag);
        chk({tag, "_pulse_left"}, exp_p.size(), 0);
        chk({tag, "_snap_left"}, exp_s.size(), 0);
    endtask

    always @(negedge CLK) begin
        pulse_t pe;
        snap_t  se;
        for (int c = 0; c < NCH; c++) begin
            if (TRIG_PULSE[c]) begin
                if (exp_p.size() == 0) chk("pulse_extra", TRIG_PULSE[c], 1'b0);
                else begin
                    pe = exp_p.pop_front();
                    chk("pulse_ch", c, pe.ch);
                    chk("pulse_cyc", cyc, pe.cyc);
                end
            end
        end
        if (SCALER_VALID) begin
            if (exp_s.size() == 0) chk("valid_extra", SCALER_VALID, 1'b0);
            else begin
                se = exp_s.pop_front();
                chk("snap_cyc", cyc, se.cyc);
                chk("snap_cnt", SCALER_OUT, se.cnt);
                chk("snap_ovf", OVERFLOW, se.ovf);
            end
        end
    end

    initial begin
        // Reset: an edge during CLR must not leave anything armed.
        step(2);
        fire(6, 1'b0);
        step(1);
        chk("rst_pulse", TRIG_PULSE, 0);
        chk("rst_level", TRIG_LEVEL, 0);
        chk("rst_scaler", SCALER_OUT, 0);
        chk("rst_ovf", OVERFLOW, 0);
        chk("rst_valid", SCALER_VALID, 0);
        CLR = 1'b0;
        step(10);
        drain("rst");

        // Basic pulse on ch2 with level window.
        fire(2, 1'b1);
        for (int j = 1; j <= 6; j++) begin
            step(1);
            chk("t1_level", TRIG_LEVEL, (j >= 3 && j <= 5) ? 8'h04 : 8'h00);
        end
        step(4);
        gate_one(2, 1, 1'b0);
        step(3);
        drain("t1");

        // Masked: level still runs, latch rearms, no count.
        MASK = 8'h04;
        fire(2, 1'b0);
        step(3);
        chk("t2_level_a", TRIG_LEVEL, 8'h04);
        step(3);
        fire(2, 1'b0);
        step(3);
        chk("t2_level_b", TRIG_LEVEL, 8'h04);
        step(6);
        MASK = '0;
        gate_one(2, 0, 1'b0);
        step(3);
        drain("t2");

        // Holdoff drops the second hit; with HOLDOFF=0 both count.
        HOLDOFF = 4'd10;
        fire(0, 1'b1);
        step(7);
        fire(0, 1'b0);
        step(20);
        gate_one(0, 1, 1'b0);
        step(2);
        HOLDOFF = 4'd0;
        fire(0, 1'b1);
        step(7);
        fire(0, 1'b1);
        step(10);
        gate_one(0, 2, 1'b0);
        step(3);
        drain("t3");

        // Merge: second edge while latch still set.
        fire(1, 1'b1);
        step(2);
        fire(1, 1'b0);
        step(12);
        gate_one(1, 1, 1'b0);
        step(3);
        drain("t4");

        // Saturation at 15 with overflow, then a clean empty period.
        for (int i = 0; i < 20; i++) begin
            fire(3, 1'b1);
            step(8);
        end
        gate_one(3, 15, 1'b1);
        step(3);
        gate_one(3, 0, 1'b0);
        step(3);
        drain("t5");

        // GATE coincident with the ch4 issue edge: excluded now, seen next period.
        fire(4, 1'b1);
        step(2);
        gate_one(4, 0, 1'b0);
        step(4);
        gate_one(4, 1, 1'b0);
        step(3);

        // CLR mid-holdoff with ch5 latch set, then a fresh edge must pass.
        HOLDOFF = 4'd15;
        fire(5, 1'b1);
        step(7);
        fire(5, 1'b0);
        step(1);
        chk("t6_pre_scaler", SCALER_OUT, 32'h0001_0000);
        CLR = 1'b1;
        #1;
        chk("t6_clr_scaler", SCALER_OUT, 0);
        chk("t6_clr_pulse", TRIG_PULSE, 0);
        chk("t6_clr_level", TRIG_LEVEL, 0);
        chk("t6_clr_ovf", OVERFLOW, 0);
        chk("t6_clr_valid", SCALER_VALID, 0);
        step(1);
        CLR = 1'b0;
        step(3);
        fire(5, 1'b1);
        step(10);
        gate_one(5, 1, 1'b0);
        step(3);
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
